// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory-side signals of the shared memory port.
// The arbiter connects through the slave modport; the requesters/memory side through master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   i_rd_addr;
  logic                i_rd_enable;
  logic [DATA_W-1:0]   i_rd_data;
  logic                i_rd_ready;
  logic                i_error;

  logic [ADDR_W-1:0]   d_addr;
  logic                d_enable;
  logic                d_wr_en;
  logic [DATA_W-1:0]   d_wr_data;
  logic [DATA_W/8-1:0] d_wr_strb;
  logic [DATA_W-1:0]   d_rd_data;
  logic                d_ready;
  logic                d_error;

  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_enable;
  logic                mem_wr_en;
  logic [DATA_W-1:0]   mem_wr_data;
  logic [DATA_W/8-1:0] mem_wr_strb;
  logic [DATA_W-1:0]   mem_rd_data;
  logic                mem_ready;

  modport slave (
    input  i_rd_addr, i_rd_enable,
    output i_rd_data, i_rd_ready, i_error,
    input  d_addr, d_enable, d_wr_en, d_wr_data, d_wr_strb,
    output d_rd_data, d_ready, d_error,
    output mem_addr, mem_enable, mem_wr_en, mem_wr_data, mem_wr_strb,
    input  mem_rd_data, mem_ready
  );

  modport master (
    output i_rd_addr, i_rd_enable,
    input  i_rd_data, i_rd_ready, i_error,
    output d_addr, d_enable, d_wr_en, d_wr_data, d_wr_strb,
    input  d_rd_data, d_ready, d_error,
    input  mem_addr, mem_enable, mem_wr_en, mem_wr_data, mem_wr_strb,
    output mem_rd_data, mem_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (I) and load/store (D),
// with flush draining and a per-transaction timeout.
//
// state     | meaning
// ----------|------------------------------------------------------------
// ST_IDLE   | no transaction; arbitrate the two requests every edge
// ST_BUSY_I | fetch transaction on the memory port, waiting for mem_ready
// ST_BUSY_D | load/store transaction on the memory port, waiting for mem_ready
// ST_DRAIN  | owner withdrew; keep mem_enable until memory finishes, drop response
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_wr_en_q, mem_wr_en_d;
  logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic [STRB_W-1:0]   mem_wr_strb_q, mem_wr_strb_d;

  logic [DATA_W-1:0]   i_rd_data_q, i_rd_data_d;
  logic                i_rd_ready_q, i_rd_ready_d;
  logic                i_error_q, i_error_d;
  logic [DATA_W-1:0]   d_rd_data_q, d_rd_data_d;
  logic                d_ready_q, d_ready_d;
  logic                d_error_q, d_error_d;

  logic                owner_en;
  logic                timeout_hit;
  logic                end_txn;
  logic                rsp_fire;
  logic                rsp_err;
  logic [DATA_W-1:0]   rsp_data;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_enable_d  = mem_enable_q;
    mem_wr_en_d   = mem_wr_en_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_strb_d = mem_wr_strb_q;
    i_rd_data_d   = i_rd_data_q;
    i_rd_ready_d  = 1'b0;
    i_error_d     = 1'b0;
    d_rd_data_d   = d_rd_data_q;
    d_ready_d     = 1'b0;
    d_error_d     = 1'b0;
    end_txn       = 1'b0;
    rsp_fire      = 1'b0;
    rsp_err       = 1'b0;
    rsp_data      = '0;
    owner_en      = (owner_q == GRANT_D) ? bus.d_enable : bus.i_rd_enable;
    timeout_hit   = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    case (state_q)
      ST_IDLE: begin
        if (bus.i_rd_enable || bus.d_enable) begin
          cnt_d        = '0;
          mem_enable_d = 1'b1;
          // D wins a tie only when I was served last
          if (bus.d_enable && (!bus.i_rd_enable || last_grant_q == GRANT_I)) begin
            owner_d       = GRANT_D;
            state_d       = ST_BUSY_D;
            mem_addr_d    = bus.d_addr;
            mem_wr_en_d   = bus.d_wr_en;
            mem_wr_data_d = bus.d_wr_data;
            mem_wr_strb_d = bus.d_wr_strb;
          end else begin
            owner_d       = GRANT_I;
            state_d       = ST_BUSY_I;
            mem_addr_d    = bus.i_rd_addr;
            mem_wr_en_d   = 1'b0;
            mem_wr_data_d = '0;
            mem_wr_strb_d = '0;
          end
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.mem_ready) begin
          end_txn  = 1'b1;
          rsp_fire = 1'b1;
          rsp_data = mem_wr_en_q ? '0 : bus.mem_rd_data;
        end else if (timeout_hit) begin
          // a requester that has already withdrawn gets no error pulse
          end_txn  = 1'b1;
          rsp_fire = owner_en;
          rsp_err  = 1'b1;
        end else if (!owner_en) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.mem_ready || timeout_hit) begin
          end_txn = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (end_txn) begin
      state_d      = ST_IDLE;
      mem_enable_d = 1'b0;
      last_grant_d = owner_q;
    end

    if (rsp_fire) begin
      if (owner_q == GRANT_D) begin
        d_ready_d   = 1'b1;
        d_error_d   = rsp_err;
        d_rd_data_d = rsp_data;
      end else begin
        i_rd_ready_d = 1'b1;
        i_error_d    = rsp_err;
        i_rd_data_d  = rsp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      owner_q       <= GRANT_I;
      last_grant_q  <= GRANT_I;
      cnt_q         <= '0;
      mem_addr_q    <= '0;
      mem_enable_q  <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_data_q <= '0;
      mem_wr_strb_q <= '0;
      i_rd_data_q   <= '0;
      i_rd_ready_q  <= 1'b0;
      i_error_q     <= 1'b0;
      d_rd_data_q   <= '0;
      d_ready_q     <= 1'b0;
      d_error_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_enable_q  <= mem_enable_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_strb_q <= mem_wr_strb_d;
      i_rd_data_q   <= i_rd_data_d;
      i_rd_ready_q  <= i_rd_ready_d;
      i_error_q     <= i_error_d;
      d_rd_data_q   <= d_rd_data_d;
      d_ready_q     <= d_ready_d;
      d_error_q     <= d_error_d;
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_enable  = mem_enable_q;
  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.mem_wr_strb = mem_wr_strb_q;
  assign bus.i_rd_data   = i_rd_data_q;
  assign bus.i_rd_ready  = i_rd_ready_q;
  assign bus.i_error     = i_error_q;
  assign bus.d_rd_data   = d_rd_data_q;
  assign bus.d_ready     = d_ready_q;
  assign bus.d_error     = d_error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected memory
// transactions and responses; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [31:0] K = 32'h5A5A_0000;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  rsp_t exp_i[$];
  rsp_t exp_d[$];
  req_t exp_m[$];
  rsp_t ei, ed;
  req_t em;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   mem_lat = 0;
  int   mem_cnt = 0;
  logic prev_en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_m(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] s);
    req_t r;
    r.addr = a; r.wr = w; r.wdata = wd; r.strb = s;
    exp_m.push_back(r);
  endtask

  task automatic push_rsp(input bit is_d, input logic [31:0] data, input logic err);
    rsp_t r;
    r.data = data; r.err = err;
    if (is_d) exp_d.push_back(r);
    else exp_i.push_back(r);
  endtask

  // requesters drop enable once they see their ready; wait until everything is quiet
  task automatic wait_quiet(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (bus.i_rd_ready) bus.i_rd_enable = 1'b0;
      if (bus.d_ready) bus.d_enable = 1'b0;
      if (!bus.i_rd_enable && !bus.d_enable && !bus.mem_enable) break;
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL %s: no completion within %0d cycles", name, budget);
      bus.i_rd_enable = 1'b0;
      bus.d_enable    = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // memory model: ready mem_lat cycles after mem_enable is seen (0 = never)
  initial begin
    bus.mem_ready   = 1'b0;
    bus.mem_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.mem_enable) begin
        mem_cnt         = 0;
        bus.mem_ready   = 1'b0;
        bus.mem_rd_data = '0;
      end else begin
        mem_cnt++;
        if (mem_lat != 0 && mem_cnt >= mem_lat) begin
          bus.mem_ready   = 1'b1;
          bus.mem_rd_data = bus.mem_addr ^ K;
        end else begin
          bus.mem_ready   = 1'b0;
          bus.mem_rd_data = 32'hDEAD_0000 | 32'(mem_cnt);
        end
      end
    end
  end

  // monitor
  initial begin
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.i_rd_ready) begin
        total++;
        if (exp_i.size() == 0) begin
          bad++;
          $display("FAIL i_rsp_unexpected: got data=%h err=%b, required no i_rd_ready", bus.i_rd_data, bus.i_error);
        end else begin
          ei = exp_i.pop_front();
          if (bus.i_rd_data !== ei.data || bus.i_error !== ei.err) begin
            bad++;
            $display("FAIL i_rsp: got data=%h err=%b, required data=%h err=%b", bus.i_rd_data, bus.i_error, ei.data, ei.err);
          end
        end
      end
      if (bus.d_ready) begin
        total++;
        if (exp_d.size() == 0) begin
          bad++;
          $display("FAIL d_rsp_unexpected: got data=%h err=%b, required no d_ready", bus.d_rd_data, bus.d_error);
        end else begin
          ed = exp_d.pop_front();
          if (bus.d_rd_data !== ed.data || bus.d_error !== ed.err) begin
            bad++;
            $display("FAIL d_rsp: got data=%h err=%b, required data=%h err=%b", bus.d_rd_data, bus.d_error, ed.data, ed.err);
          end
        end
      end
      if (bus.mem_enable && !prev_en) begin
        total++;
        if (exp_m.size() == 0) begin
          bad++;
          $display("FAIL mem_unexpected: got addr=%h wr=%b, required no transaction", bus.mem_addr, bus.mem_wr_en);
        end else begin
          em = exp_m.pop_front();
          if (bus.mem_addr !== em.addr || bus.mem_wr_en !== em.wr ||
              bus.mem_wr_data !== em.wdata || bus.mem_wr_strb !== em.strb) begin
            bad++;
            $display("FAIL mem_req: got addr=%h wr=%b wdata=%h strb=%h, required addr=%h wr=%b wdata=%h strb=%h",
                     bus.mem_addr, bus.mem_wr_en, bus.mem_wr_data, bus.mem_wr_strb,
                     em.addr, em.wr, em.wdata, em.strb);
          end
        end
      end
      prev_en = bus.mem_enable;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0, t1;
    reset           = 1'b0;
    bus.i_rd_addr   = '0;
    bus.i_rd_enable = 1'b0;
    bus.d_addr      = '0;
    bus.d_enable    = 1'b0;
    bus.d_wr_en     = 1'b0;
    bus.d_wr_data   = '0;
    bus.d_wr_strb   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_enable", bus.mem_enable, 0);
    chk("rst_mem_wr_en", bus.mem_wr_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_i_rd_ready", bus.i_rd_ready, 0);
    chk("rst_d_ready", bus.d_ready, 0);
    chk("rst_errors", {bus.i_error, bus.d_error}, 0);
    chk("rst_rd_data", {bus.i_rd_data, bus.d_rd_data}, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 1: I-only read
    mem_lat = 2;
    push_m(32'h100, 1'b0, 32'h0, 4'h0);
    push_rsp(1'b0, 32'h100 ^ K, 1'b0);
    bus.i_rd_addr   = 32'h100;
    bus.i_rd_enable = 1'b1;
    wait_quiet("t1_i_read", 50);

    // 2: contention, D first, then I; repeat contention grants D again
    mem_lat = 1;
    push_m(32'h2000, 1'b0, 32'h0, 4'h0);
    push_m(32'h1000, 1'b0, 32'h0, 4'h0);
    push_rsp(1'b1, 32'h2000 ^ K, 1'b0);
    push_rsp(1'b0, 32'h1000 ^ K, 1'b0);
    bus.i_rd_addr   = 32'h1000;
    bus.d_addr      = 32'h2000;
    bus.d_wr_en     = 1'b0;
    bus.i_rd_enable = 1'b1;
    bus.d_enable    = 1'b1;
    wait_quiet("t2_contend_a", 60);
    push_m(32'h2004, 1'b0, 32'h0, 4'h0);
    push_m(32'h1004, 1'b0, 32'h0, 4'h0);
    push_rsp(1'b1, 32'h2004 ^ K, 1'b0);
    push_rsp(1'b0, 32'h1004 ^ K, 1'b0);
    bus.i_rd_addr   = 32'h1004;
    bus.d_addr      = 32'h2004;
    bus.i_rd_enable = 1'b1;
    bus.d_enable    = 1'b1;
    wait_quiet("t2_contend_b", 60);

    // 3: D write
    mem_lat = 2;
    push_m(32'h40, 1'b1, 32'hDEADBEEF, 4'hF);
    push_rsp(1'b1, 32'h0, 1'b0);
    bus.d_addr      = 32'h40;
    bus.d_wr_en     = 1'b1;
    bus.d_wr_data   = 32'hDEADBEEF;
    bus.d_wr_strb   = 4'hF;
    bus.d_enable    = 1'b1;
    wait_quiet("t3_d_write", 50);
    bus.d_wr_en     = 1'b0;
    bus.d_wr_data   = '0;
    bus.d_wr_strb   = '0;

    // 4: fetch flush while a D request waits; no I response, D served after drain
    mem_lat = 5;
    push_m(32'h300, 1'b0, 32'h0, 4'h0);
    push_m(32'h500, 1'b0, 32'h0, 4'h0);
    push_rsp(1'b1, 32'h500 ^ K, 1'b0);
    bus.i_rd_addr   = 32'h300;
    bus.i_rd_enable = 1'b1;
    n = 0;
    while (!bus.mem_enable && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t4_grant_seen", n < 20, 1);
    @(posedge clk);
    #1;
    bus.i_rd_enable = 1'b0;
    bus.d_addr      = 32'h500;
    bus.d_enable    = 1'b1;
    wait_quiet("t4_flush", 80);

    // 5: timeout on a D read
    mem_lat = 0;
    push_m(32'h600, 1'b0, 32'h0, 4'h0);
    push_rsp(1'b1, 32'h0, 1'b1);
    bus.d_addr   = 32'h600;
    bus.d_enable = 1'b1;
    n = 0;
    while (!bus.mem_enable && n < 20) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    n = 0;
    while (!bus.d_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    t1 = cyc;
    chk("t5_timeout_latency", t1 - t0, TO);
    chk("t5_mem_enable_dropped", bus.mem_enable, 0);
    bus.d_enable = 1'b0;
    wait_quiet("t5_timeout", 30);

    // 6: reset in the middle of a D transaction
    push_m(32'h700, 1'b0, 32'h0, 4'h0);
    bus.d_addr   = 32'h700;
    bus.d_enable = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_mem_enable", bus.mem_enable, 0);
    chk("t6_mem_addr", bus.mem_addr, 0);
    chk("t6_mem_wr", {bus.mem_wr_en, bus.mem_wr_data, bus.mem_wr_strb}, 0);
    chk("t6_readys", {bus.i_rd_ready, bus.d_ready}, 0);
    chk("t6_i_rd_data", bus.i_rd_data, 0);
    bus.d_enable = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("t6_idle_after_release", bus.mem_enable, 0);

    // 7: contention right after reset grants D first again
    mem_lat = 1;
    push_m(32'h2100, 1'b0, 32'h0, 4'h0);
    push_m(32'h1100, 1'b0, 32'h0, 4'h0);
    push_rsp(1'b1, 32'h2100 ^ K, 1'b0);
    push_rsp(1'b0, 32'h1100 ^ K, 1'b0);
    bus.i_rd_addr   = 32'h1100;
    bus.d_addr      = 32'h2100;
    bus.i_rd_enable = 1'b1;
    bus.d_enable    = 1'b1;
    wait_quiet("t7_post_reset", 60);

    repeat (3) @(posedge clk);
    #1;
    chk("end_exp_i_left", exp_i.size(), 0);
    chk("end_exp_d_left", exp_d.size(), 0);
    chk("end_exp_m_left", exp_m.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
